// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage: fetch FSM, one-outstanding imem handshake, IF/ID register
// Optional feature macro: IF_PERF_CNT_EN (adds fetch_cnt/drop_cnt outputs)
module instruction_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] jump_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] drop_cnt
`endif
);

  typedef enum logic [2:0] {
    F_IDLE = 3'd0,
    F_REQ  = 3'd1,
    F_WAIT = 3'd2,
    F_HOLD = 3'd3,
    F_DROP = 3'd4
  } fetch_state_e;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  buf_inst_q, buf_inst_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic         valid_q, valid_d;
  logic         capture;
  logic [31:0]  cap_inst;
  logic [31:0]  cap_pc;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    inst_d     = stall ? inst_q  : NOP_INST;
    out_pc_d   = out_pc_q;
    valid_d    = stall ? valid_q : 1'b0;
    capture    = 1'b0;
    cap_inst   = imem_rdata;
    cap_pc     = req_pc_q;

    case (state_q)
      F_IDLE: state_d = F_REQ;
      F_REQ: begin
        if (imem_gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = F_WAIT;
        end
      end
      F_WAIT: begin
        if (imem_rvalid) begin
          if (stall) begin
            buf_inst_d = imem_rdata;
            buf_pc_d   = req_pc_q;
            state_d    = F_HOLD;
          end else begin
            capture = 1'b1;
            state_d = F_REQ;
          end
        end
      end
      F_HOLD: begin
        if (!stall) begin
          capture  = 1'b1;
          cap_inst = buf_inst_q;
          cap_pc   = buf_pc_q;
          state_d  = F_REQ;
        end
      end
      F_DROP: begin
        if (imem_rvalid) state_d = F_REQ;
      end
      default: state_d = F_IDLE;
    endcase

    // A redirect squashes whatever is in flight; an already-granted request becomes stale.
    if (branch_taken) begin
      pc_d    = jump_addr & ~32'h3;
      capture = 1'b0;
      case (state_q)
        F_IDLE:  state_d = F_IDLE;
        F_REQ:   state_d = imem_gnt    ? F_DROP : F_REQ;
        F_WAIT:  state_d = imem_rvalid ? F_REQ  : F_DROP;
        F_HOLD:  state_d = F_REQ;
        F_DROP:  state_d = imem_rvalid ? F_REQ  : F_DROP;
        default: state_d = F_IDLE;
      endcase
    end

    if (capture) begin
      inst_d   = cap_inst;
      out_pc_d = cap_pc;
      valid_d  = 1'b1;
    end else if (branch_taken) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= F_IDLE;
      pc_q       <= RESET_ADDR;
      req_pc_q   <= 32'd0;
      buf_inst_q <= 32'd0;
      buf_pc_q   <= 32'd0;
      inst_q     <= NOP_INST;
      out_pc_q   <= 32'd0;
      valid_q    <= 1'b0;
    end else if (clk_en) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
      inst_q     <= inst_d;
      out_pc_q   <= out_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_req   = (state_q == F_REQ);
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign pc         = out_pc_q;
  assign inst_valid = valid_q;

`ifdef IF_PERF_CNT_EN
  logic        discard;
  logic [31:0] fetch_cnt_q, drop_cnt_q;

  assign discard = imem_rvalid &&
                   ((state_q == F_DROP) || (state_q == F_WAIT && branch_taken));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'd0;
      drop_cnt_q  <= 32'd0;
    end else if (clk_en) begin
      if (capture) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (discard) drop_cnt_q  <= drop_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - vector table plus randomized run against a program-order reference model
module tb_instruction_fetch;

  localparam logic [31:0] RST_A = 32'h0000_0100;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] jump_addr = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  instruction_fetch #(.RESET_ADDR(RST_A), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .stall        (stall),
    .branch_taken (branch_taken),
    .jump_addr    (jump_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .inst         (inst),
    .pc           (pc),
    .inst_valid   (inst_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .drop_cnt     (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, en, stall, br;
    logic [31:0] jump;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc, inst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic e, input logic s, input logic b,
                              input logic [31:0] j, input logic g, input logic v,
                              input logic [31:0] d, input logic xq, input logic [31:0] xa,
                              input logic xv, input logic [31:0] xp, input logic [31:0] xi);
    vec_t t;
    t.rst_n = r; t.en = e; t.stall = s; t.br = b; t.jump = j; t.gnt = g; t.rv = v;
    t.rdata = d; t.req = xq; t.addr = xa; t.valid = xv; t.pc = xp; t.inst = xi;
    return t;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  logic        p_rst, p_en, p_stall, p_br, p_gnt, p_rv, p_req, p_valid;
  logic [31:0] p_jump, p_addr, p_pc, p_inst;
  logic [31:0] exp_pc, align_mask;
  logic        mpend;
  logic [31:0] maddr;
  int          mdelay;
  int          captures;

  initial begin
    // rst en st br jump gnt rv rdata | req addr valid pc inst
    vecs.push_back(mk(0,1,0,0,0,0,0,0,                 0,32'h100,0,32'h0,NOP));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,                 1,32'h100,0,32'h0,NOP));
    vecs.push_back(mk(1,1,0,0,0,1,0,0,                 0,32'h104,0,32'h0,NOP));
    vecs.push_back(mk(1,1,0,0,0,0,1,32'h0050_0093,     1,32'h104,1,32'h100,32'h0050_0093));
    vecs.push_back(mk(1,1,1,0,0,1,0,0,                 0,32'h108,1,32'h100,32'h0050_0093));
    vecs.push_back(mk(1,1,1,0,0,0,1,32'h0060_0113,     0,32'h108,1,32'h100,32'h0050_0093));
    vecs.push_back(mk(1,1,1,0,0,0,0,0,                 0,32'h108,1,32'h100,32'h0050_0093));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,                 1,32'h108,1,32'h104,32'h0060_0113));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1,1,0,0,0,0,0,0,               1,32'h108,0,32'h104,NOP));
    vecs.push_back(mk(1,1,0,0,0,1,0,0,                 0,32'h10C,0,32'h104,NOP));
    vecs.push_back(mk(1,1,0,1,32'h203,0,0,0,           0,32'h200,0,32'h104,NOP));
    vecs.push_back(mk(1,1,0,0,0,0,1,32'hDEAD_BEEF,     1,32'h200,0,32'h104,NOP));
    vecs.push_back(mk(1,1,0,0,0,1,0,0,                 0,32'h204,0,32'h104,NOP));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1,0,0,0,0,0,1,32'h0070_0193,   0,32'h204,0,32'h104,NOP));
    vecs.push_back(mk(1,1,0,0,0,0,1,32'h0070_0193,     1,32'h204,1,32'h200,32'h0070_0193));
    vecs.push_back(mk(1,1,0,0,0,1,0,0,                 0,32'h208,0,32'h200,NOP));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,                 0,32'h100,0,32'h0,NOP));
    vecs.push_back(mk(1,1,0,0,0,0,1,32'hDEAD_BEEF,     1,32'h100,0,32'h0,NOP));
    vecs.push_back(mk(1,1,0,0,0,1,0,0,                 0,32'h104,0,32'h0,NOP));
    vecs.push_back(mk(1,1,0,0,0,0,1,32'h0050_0093,     1,32'h104,1,32'h100,32'h0050_0093));
    vecs.push_back(mk(1,1,0,1,32'hFFFF_FFFE,0,0,0,     1,32'hFFFF_FFFC,0,32'h100,NOP));
    vecs.push_back(mk(1,1,0,0,0,1,0,0,                 0,32'h0,0,32'h100,NOP));
    vecs.push_back(mk(1,1,0,0,0,0,1,32'h11,            1,32'h0,1,32'hFFFF_FFFC,32'h11));
    vecs.push_back(mk(1,1,0,1,32'h300,1,0,0,           0,32'h300,0,32'hFFFF_FFFC,NOP));
    vecs.push_back(mk(1,1,0,0,0,0,1,32'h0BAD,          1,32'h300,0,32'hFFFF_FFFC,NOP));
    vecs.push_back(mk(1,1,0,0,0,1,0,0,                 0,32'h304,0,32'hFFFF_FFFC,NOP));
    vecs.push_back(mk(1,1,0,0,0,0,1,32'h22,            1,32'h304,1,32'h300,32'h22));
    vecs.push_back(mk(1,1,1,0,0,1,0,0,                 0,32'h308,1,32'h300,32'h22));
    vecs.push_back(mk(1,1,1,0,0,0,1,32'h33,            0,32'h308,1,32'h300,32'h22));
    vecs.push_back(mk(1,1,0,1,32'h400,0,0,0,           1,32'h400,0,32'h300,NOP));

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; clk_en = vecs[i].en; stall = vecs[i].stall;
      branch_taken = vecs[i].br; jump_addr = vecs[i].jump; imem_gnt = vecs[i].gnt;
      imem_rvalid = vecs[i].rv; imem_rdata = vecs[i].rdata;
      @(posedge clk); #1;
      check($sformatf("vec%0d_req", i),   {31'd0, imem_req},   {31'd0, vecs[i].req});
      check($sformatf("vec%0d_addr", i),  imem_addr,           vecs[i].addr);
      check($sformatf("vec%0d_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].valid});
      check($sformatf("vec%0d_pc", i),    pc,                  vecs[i].pc);
      check($sformatf("vec%0d_inst", i),  inst,                vecs[i].inst);
    end

    // Randomized run: valid outputs must follow program order from reset or the last redirect.
    align_mask = ~32'h3;
    mpend = 1'b0; maddr = 32'd0; mdelay = 0; exp_pc = RST_A; captures = 0;
    for (int c = 0; c < 4000; c++) begin
      rst_n        = (c >= 2);
      clk_en       = ($urandom_range(0, 9) != 0);
      stall        = ($urandom_range(0, 4) == 0);
      branch_taken = !stall && ($urandom_range(0, 15) == 0);
      jump_addr    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                 : ($urandom & 32'h0000_3FFF);
      imem_gnt     = imem_req && ($urandom_range(0, 3) != 0);
      if (mpend && mdelay == 0) begin
        imem_rvalid = 1'b1; imem_rdata = mem_word(maddr);
      end else begin
        imem_rvalid = 1'b0; imem_rdata = $urandom;
      end
      p_rst = rst_n; p_en = clk_en; p_stall = stall; p_br = branch_taken; p_jump = jump_addr;
      p_gnt = imem_gnt; p_rv = imem_rvalid; p_req = imem_req; p_addr = imem_addr;
      p_valid = inst_valid; p_pc = pc; p_inst = inst;
      @(posedge clk); #1;

      if (!p_rst) begin
        check("rnd_rst_req",   {31'd0, imem_req},   32'd0);
        check("rnd_rst_addr",  imem_addr,           RST_A);
        check("rnd_rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rnd_rst_inst",  inst,                NOP);
        exp_pc = RST_A;
      end else if (!p_en) begin
        check("rnd_en_req",   {31'd0, imem_req},   {31'd0, p_req});
        check("rnd_en_addr",  imem_addr,           p_addr);
        check("rnd_en_valid", {31'd0, inst_valid}, {31'd0, p_valid});
        check("rnd_en_pc",    pc,                  p_pc);
        check("rnd_en_inst",  inst,                p_inst);
      end else begin
        if (p_br) begin
          check("rnd_br_valid", {31'd0, inst_valid}, 32'd0);
          check("rnd_br_inst",  inst,                NOP);
          exp_pc = p_jump & align_mask;
        end else if (p_stall) begin
          check("rnd_stall_valid", {31'd0, inst_valid}, {31'd0, p_valid});
          check("rnd_stall_pc",    pc,                  p_pc);
          check("rnd_stall_inst",  inst,                p_inst);
        end else if (inst_valid) begin
          check("rnd_order_pc",   pc,   exp_pc);
          check("rnd_order_inst", inst, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
          captures++;
        end else begin
          check("rnd_bubble_inst", inst, NOP);
          check("rnd_bubble_pc",   pc,   p_pc);
        end
        if (p_req && !p_gnt && !p_br) begin
          check("rnd_req_held",  {31'd0, imem_req}, 32'd1);
          check("rnd_addr_held", imem_addr,         p_addr);
        end
      end

      if (!p_rst) mpend = 1'b0;
      else if (p_en) begin
        if (p_rv) mpend = 1'b0;
        else if (mpend && mdelay > 0) mdelay--;
        if (p_req && p_gnt) begin
          mpend = 1'b1; maddr = p_addr; mdelay = $urandom_range(0, 2);
        end
      end
      if (imem_req) check("rnd_one_outstanding", {31'd0, mpend}, 32'd0);
    end

    check("rnd_liveness", {31'd0, (captures > 100)}, 32'd1);
`ifdef IF_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, captures);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
